// File: rtl/ex_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// ex_fwd_hazard_ctrl
//
// Forwarding and load-use hazard controller for the 5-stage core.
// Keeps a private shadow of the destination-register info for the MEM and
// WB stages (advanced every clock, never frozen) and uses it to produce the
// EX operand-select codes. A two-state FSM (RUN/STALL) produces the one-cycle
// load-use stall and the ID/EX bubble. A redirect (flush) always beats a
// stall.
//
// Optional feature: define HAZ_PERF_CNT_EN to add the stall_cnt / fwd_cnt
// performance counters. Without it those ports and registers do not exist.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   id_rs1/id_rs2       : ID-stage source indices
//   id_use_rs1/_rs2     : ID instruction really reads rs1/rs2
//   id_valid            : ID holds a real instruction
//   ex_rs1/ex_rs2       : EX-stage source indices
//   ex_rd               : EX-stage destination index
//   ex_reg_write        : EX instruction writes rd
//   ex_mem_read         : EX instruction is a load
//   ex_valid            : EX holds a real instruction
//   flush               : taken branch/jump resolved in EX
//   rd1_ctr/rd2_ctr     : 00 regfile, 01 EX/MEM ALU result, 11 WB result
//   stall_if/stall_id   : hold PC and IF/ID register
//   bubble_ex           : load a NOP into ID/EX on the next edge
//   stall_cnt/fwd_cnt   : performance counters (HAZ_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module ex_fwd_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_valid,
  input  logic                      flush,
  output logic [1:0]                rd1_ctr,
  output logic [1:0]                rd2_ctr,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      bubble_ex
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      fwd_cnt
`endif
);

  localparam logic [REG_ADDR_WIDTH-1:0] RegZero = '0;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } state_e;

  state_e state_q, state_d;

  // Shadow pipeline: MEM and WB destination info.
  logic [REG_ADDR_WIDTH-1:0] mem_rd_q, wb_rd_q;
  logic                      mem_we_q, mem_ld_q, mem_v_q;
  logic                      wb_we_q, wb_v_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_q <= '0;
      mem_we_q <= 1'b0;
      mem_ld_q <= 1'b0;
      mem_v_q  <= 1'b0;
      wb_rd_q  <= '0;
      wb_we_q  <= 1'b0;
      wb_v_q   <= 1'b0;
      state_q  <= ST_RUN;
    end else begin
      mem_rd_q <= ex_rd;
      mem_we_q <= ex_reg_write;
      mem_ld_q <= ex_mem_read;
      mem_v_q  <= ex_valid;
      wb_rd_q  <= mem_rd_q;
      wb_we_q  <= mem_we_q;
      wb_v_q   <= mem_v_q;
      state_q  <= state_d;
    end
  end

  // A load in MEM is excluded: the EX/MEM bus still carries its address.
  function automatic logic mem_hit(input logic [REG_ADDR_WIDTH-1:0] src);
    return mem_v_q & mem_we_q & ~mem_ld_q & (mem_rd_q != RegZero) & (mem_rd_q == src);
  endfunction

  function automatic logic wb_hit(input logic [REG_ADDR_WIDTH-1:0] src);
    return wb_v_q & wb_we_q & (wb_rd_q != RegZero) & (wb_rd_q == src);
  endfunction

  // MEM is checked first because it holds the younger value.
  function automatic logic [1:0] sel_ctr(input logic [REG_ADDR_WIDTH-1:0] src);
    if (mem_hit(src))     return 2'b01;
    else if (wb_hit(src)) return 2'b11;
    else                  return 2'b00;
  endfunction

  always_comb begin
    rd1_ctr = sel_ctr(ex_rs1);
    rd2_ctr = sel_ctr(ex_rs2);
  end

  logic lu;
  assign lu = ex_valid & ex_mem_read & (ex_rd != RegZero) & id_valid &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d   = state_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    // Outputs are also gated by rst so that a reset landing in the middle of
    // a stall cycle drops them at once, even though lu may still be true.
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (flush) begin
            state_d = ST_RUN;
          end else if (lu) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
            state_d   = ST_STALL;
          end
        end
        // Bubble is in EX, load in MEM: nothing to do this cycle.
        ST_STALL: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_if) stall_cnt_q <= stall_cnt_q + CntOne;
      // One count per cycle, however many operands are forwarded.
      if ((rd1_ctr != 2'b00) || (rd2_ctr != 2'b00)) fwd_cnt_q <= fwd_cnt_q + CntOne;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_ex_fwd_hazard_ctrl.sv
module tb_ex_fwd_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, id_valid;
  logic          ex_reg_write, ex_mem_read, ex_valid, flush;
  logic [1:0]    rd1_ctr, rd2_ctr;
  logic          stall_if, stall_id, bubble_ex;
`ifdef HAZ_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, fwd_cnt;
`endif

  ex_fwd_hazard_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_valid(id_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_valid(ex_valid),
    .flush(flush),
    .rd1_ctr(rd1_ctr), .rd2_ctr(rd2_ctr),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string    nm;
    logic [1:0] c1;
    logic [1:0] c2;
    logic     st;
    int       sc;
    int       fc;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tot_stall = 0;
  int   tot_fwd = 0;

  // ---------------- stimulus helpers ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic we, input logic ld,
                        input logic v);
    ex_rs1 = rs1; ex_rs2 = rs2; ex_rd = rd;
    ex_reg_write = we; ex_mem_read = ld; ex_valid = v;
  endtask

  task automatic set_id(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic u1, input logic u2, input logic v);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2; id_valid = v;
  endtask

  // Push expected outputs for the current cycle; counters expected are the
  // totals of all earlier cycles since the last reset.
  task automatic push_exp(input string nm, input logic [1:0] c1, input logic [1:0] c2,
                          input logic st);
    exp_t e;
    e.nm = nm; e.c1 = c1; e.c2 = c2; e.st = st;
    e.sc = tot_stall; e.fc = tot_fwd;
    q.push_back(e);
    if (st) tot_stall++;
    if (c1 != 2'b00 || c2 != 2'b00) tot_fwd++;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, want);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        cmp(e.nm, "rd1_ctr",   32'(rd1_ctr),   32'(e.c1));
        cmp(e.nm, "rd2_ctr",   32'(rd2_ctr),   32'(e.c2));
        cmp(e.nm, "stall_if",  32'(stall_if),  32'(e.st));
        cmp(e.nm, "stall_id",  32'(stall_id),  32'(e.st));
        cmp(e.nm, "bubble_ex", 32'(bubble_ex), 32'(e.st));
`ifdef HAZ_PERF_CNT_EN
        cmp(e.nm, "stall_cnt", 32'(stall_cnt), 32'(e.sc));
        cmp(e.nm, "fwd_cnt",   32'(fwd_cnt),   32'(e.fc));
`endif
        $display("txn %-22s ctr=%b/%b stall=%b bubble=%b", e.nm, rd1_ctr, rd2_ctr,
                 stall_if, bubble_ex);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed vectors ----------------
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0);
    set_id(0, 0, 0, 0, 0);
    #1;
    push_exp("in_reset", 2'b00, 2'b00, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    nxt(); push_exp("idle_after_reset", 2'b00, 2'b00, 1'b0);

    // add x5, then consumer of x5 on both operands (MEM), then rs2 only (WB)
    nxt(); set_ex(0, 0, 5, 1, 0, 1); push_exp("add_x5", 2'b00, 2'b00, 1'b0);
    nxt(); set_ex(5, 5, 0, 0, 0, 1); push_exp("mem_fwd_both", 2'b01, 2'b01, 1'b0);
    nxt(); set_ex(0, 5, 0, 0, 0, 1); push_exp("wb_fwd_rs2", 2'b00, 2'b11, 1'b0);

    // two writes of x7 back-to-back: MEM must beat WB
    nxt(); set_ex(0, 0, 7, 1, 0, 1); push_exp("add_x7_a", 2'b00, 2'b00, 1'b0);
    nxt(); set_ex(7, 0, 7, 1, 0, 1); push_exp("add_x7_b_mem", 2'b01, 2'b00, 1'b0);
    nxt(); set_ex(7, 7, 0, 0, 0, 1); push_exp("x7_mem_wins", 2'b01, 2'b01, 1'b0);

    // writes to x0 never forward, even to a source index of 0
    nxt(); set_ex(0, 0, 0, 1, 0, 1); push_exp("wr_x0_a", 2'b00, 2'b00, 1'b0);
    nxt(); set_ex(0, 0, 0, 1, 0, 1); push_exp("wr_x0_b", 2'b00, 2'b00, 1'b0);
    nxt(); set_ex(0, 0, 0, 0, 0, 1); push_exp("x0_no_fwd", 2'b00, 2'b00, 1'b0);

    // lw x3 in EX, ID reads x3 via rs2 -> one stall cycle
    nxt(); set_ex(0, 0, 3, 1, 1, 1); set_id(0, 3, 0, 1, 1);
    push_exp("lu_stall", 2'b00, 2'b00, 1'b1);
    // STALL state ignores a load-use condition still presented
    nxt(); push_exp("stall_state_quiet", 2'b00, 2'b00, 1'b0);
    // dependent in EX, load in WB (and a load in MEM must not give 01)
    nxt(); set_ex(0, 3, 0, 0, 0, 1); set_id(0, 0, 0, 0, 0);
    push_exp("lu_wb_fwd", 2'b00, 2'b11, 1'b0);

    // same load-use with flush: no stall, state remains RUN
    nxt(); set_ex(0, 0, 3, 1, 1, 1); set_id(0, 3, 0, 1, 1); flush = 1'b1;
    push_exp("flush_no_stall", 2'b00, 2'b00, 1'b0);
    nxt(); flush = 1'b0;
    push_exp("run_after_flush", 2'b00, 2'b00, 1'b1);

    // reset in the middle of that stall cycle
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    tot_stall = 0; tot_fwd = 0;
    push_exp("rst_mid_stall", 2'b00, 2'b00, 1'b0);
    -> chk_ev;
    #1;
    set_ex(0, 0, 3, 1, 1, 1); set_id(0, 0, 0, 0, 0);
    rst = 1'b0;

    nxt(); set_ex(3, 3, 0, 0, 0, 1);
    push_exp("rst_mem_load_no01", 2'b00, 2'b00, 1'b0);
    nxt(); push_exp("rst_wb_load_fwd", 2'b11, 2'b11, 1'b0);

    // load-use qualifiers: use flag off, x0 destination, rs1 path
    nxt(); set_ex(0, 0, 9, 1, 1, 1); set_id(0, 9, 0, 0, 1);
    push_exp("lu_use_flag_off", 2'b00, 2'b00, 1'b0);
    nxt(); set_ex(0, 0, 0, 1, 1, 1); set_id(0, 0, 1, 1, 1);
    push_exp("lu_x0_no_stall", 2'b00, 2'b00, 1'b0);
    nxt(); set_ex(0, 0, 9, 1, 1, 1); set_id(9, 0, 1, 0, 1);
    push_exp("lu_rs1_stall", 2'b00, 2'b00, 1'b1);
    nxt(); set_ex(0, 0, 0, 0, 0, 0); set_id(0, 0, 0, 0, 0);
    push_exp("idle_1", 2'b00, 2'b00, 1'b0);
    nxt(); push_exp("idle_2", 2'b00, 2'b00, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
